// File: rtl/alu_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_sequencer_if
//  Description : Bus bundle between the ALU command sequencer and its
//                surroundings (UART RX/TX strobes and the combinational ALU).
//                slave  : the sequencer side (consumes RX/TX/ALU inputs,
//                         drives ALU operands and TX byte)
//                master : the environment side (UART blocks + ALU)
//  Signals     : i_rx_data/i_rx_done  received byte and its strobe
//                i_tx_done            transmitter finished strobe
//                i_alu_result         combinational ALU result
//                o_alu_a/o_alu_b/o_alu_op  operands/opcode to the ALU
//                o_tx_data/o_tx_start      result byte and start pulse
//                o_busy/o_err              status
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_cmd_sequencer_if #(
    parameter int N_BITS = 8,
    parameter int N_OP   = 6
);
    logic [N_BITS-1:0] i_rx_data;
    logic              i_rx_done;
    logic              i_tx_done;
    logic [N_BITS-1:0] i_alu_result;
    logic [N_BITS-1:0] o_alu_a;
    logic [N_BITS-1:0] o_alu_b;
    logic [N_OP-1:0]   o_alu_op;
    logic [N_BITS-1:0] o_tx_data;
    logic              o_tx_start;
    logic              o_busy;
    logic              o_err;

    modport slave (
        input  i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_err
    );

    modport master (
        output i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_sequencer
//  Description : Collects three bytes from the UART receiver (operand A,
//                operand B, opcode), presents them to the combinational ALU,
//                captures the result and hands it to the UART transmitter.
//  Ports       : clock  - system clock, rising edge
//                reset  - synchronous, active-high reset
//                bus    - alu_cmd_sequencer_if.slave (RX byte/strobe, TX
//                         done, ALU result in; ALU operands, TX byte/start,
//                         busy and error out)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
    parameter int N_BITS = 8,
    parameter int N_OP   = 6
) (
    input  wire logic            clock,
    input  wire logic            reset,
    alu_cmd_sequencer_if.slave   bus
);

    localparam logic [N_OP-1:0] c_OP_ADD = N_OP'(6'b100000);
    localparam logic [N_OP-1:0] c_OP_SUB = N_OP'(6'b100010);
    localparam logic [N_OP-1:0] c_OP_AND = N_OP'(6'b100100);
    localparam logic [N_OP-1:0] c_OP_OR  = N_OP'(6'b100101);
    localparam logic [N_OP-1:0] c_OP_XOR = N_OP'(6'b100110);
    localparam logic [N_OP-1:0] c_OP_SRA = N_OP'(6'b000011);
    localparam logic [N_OP-1:0] c_OP_SRL = N_OP'(6'b000010);
    localparam logic [N_OP-1:0] c_OP_NOR = N_OP'(6'b100111);

    typedef enum logic [2:0] {
        S_WAIT_A  = 3'd0,
        S_WAIT_B  = 3'd1,
        S_WAIT_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SEND    = 3'd4,
        S_WAIT_TX = 3'd5
    } state_t;

    state_t            state_q;
    logic [N_BITS-1:0] alu_a_q;
    logic [N_BITS-1:0] alu_b_q;
    logic [N_OP-1:0]   alu_op_q;
    logic [N_BITS-1:0] tx_data_q;
    logic              tx_start_q;
    logic              busy_q;
    logic              err_q;

    logic [N_OP-1:0]   w_op_byte;
    logic              w_op_valid;

    // Only the low N_OP bits of the opcode byte carry the opcode.
    assign w_op_byte = bus.i_rx_data[N_OP-1:0];

    always_comb begin
        w_op_valid = 1'b0;
        case (w_op_byte)
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR,
            c_OP_XOR, c_OP_SRA, c_OP_SRL, c_OP_NOR: w_op_valid = 1'b1;
            default:                                w_op_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_WAIT_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Pulse outputs default low; set for a single cycle below.
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                S_WAIT_A: begin
                    if (bus.i_rx_done) begin
                        alu_a_q <= bus.i_rx_data;
                        state_q <= S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (bus.i_rx_done) begin
                        alu_b_q <= bus.i_rx_data;
                        state_q <= S_WAIT_OP;
                    end
                end
                S_WAIT_OP: begin
                    if (bus.i_rx_done) begin
                        if (w_op_valid) begin
                            alu_op_q <= w_op_byte;
                            busy_q   <= 1'b1;
                            state_q  <= S_EXEC;
                        end else begin
                            // Drop the whole command; previous opcode stays on the ALU.
                            err_q   <= 1'b1;
                            state_q <= S_WAIT_A;
                        end
                    end
                end
                S_EXEC: begin
                    // Operands and opcode have been stable since the previous edge,
                    // so the combinational result is settled here.
                    tx_data_q  <= bus.i_alu_result;
                    tx_start_q <= 1'b1;
                    state_q    <= S_SEND;
                end
                S_SEND: begin
                    state_q <= S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    // A simultaneous RX byte is intentionally not taken as operand A.
                    if (bus.i_tx_done) begin
                        busy_q  <= 1'b0;
                        state_q <= S_WAIT_A;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_WAIT_A;
                end
            endcase
        end
    end

    assign bus.o_alu_a    = alu_a_q;
    assign bus.o_alu_b    = alu_b_q;
    assign bus.o_alu_op   = alu_op_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_start = tx_start_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cmd_sequencer
//  Description : Directed testbench for alu_cmd_sequencer. Provides a
//                behavioural ALU on the interface and drives RX/TX strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    int   start_cnt;

    alu_cmd_sequencer_if #(.N_BITS(8), .N_OP(6)) ifc ();

    alu_cmd_sequencer #(.N_BITS(8), .N_OP(6)) u_dut (
        .clock (clk),
        .reset (rst),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        logic [7:0] r;
        case (op)
            6'h20:   r = a + b;
            6'h22:   r = a - b;
            6'h24:   r = a & b;
            6'h25:   r = a | b;
            6'h26:   r = a ^ b;
            6'h03:   r = 8'($signed(a) >>> b);
            6'h02:   r = a >> b;
            6'h27:   r = ~(a | b);
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // The ALU the sequencer drives.
    assign ifc.i_alu_result = ref_alu(ifc.o_alu_a, ifc.o_alu_b, ifc.o_alu_op);

    always @(negedge clk) if (ifc.o_tx_start === 1'b1) start_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        ifc.i_rx_data = b;
        ifc.i_rx_done = 1'b1;
        @(negedge clk);
        ifc.i_rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        ifc.i_tx_done = 1'b1;
        @(negedge clk);
        ifc.i_tx_done = 1'b0;
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] exp);
        int base;
        base = start_cnt;
        send_byte(a);
        send_byte(b);
        send_byte(op);
        // EXEC cycle
        check_eq({tag, " a"},    32'(ifc.o_alu_a), 32'(a));
        check_eq({tag, " b"},    32'(ifc.o_alu_b), 32'(b));
        check_eq({tag, " op"},   32'(ifc.o_alu_op), 32'(op[5:0]));
        check_eq({tag, " busy_exec"}, 32'(ifc.o_busy), 32'd1);
        check_eq({tag, " start_exec"}, 32'(ifc.o_tx_start), 32'd0);
        @(negedge clk);
        // SEND cycle
        check_eq({tag, " start_send"}, 32'(ifc.o_tx_start), 32'd1);
        check_eq({tag, " tx_data"}, 32'(ifc.o_tx_data), 32'(exp));
        @(negedge clk);
        // WAIT_TX
        check_eq({tag, " start_wait"}, 32'(ifc.o_tx_start), 32'd0);
        check_eq({tag, " busy_wait"}, 32'(ifc.o_busy), 32'd1);
        pulse_tx_done();
        check_eq({tag, " busy_done"}, 32'(ifc.o_busy), 32'd0);
        check_eq({tag, " one_start"}, 32'(start_cnt - base), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " a0"},     32'(ifc.o_alu_a), 32'd0);
        check_eq({tag, " b0"},     32'(ifc.o_alu_b), 32'd0);
        check_eq({tag, " op0"},    32'(ifc.o_alu_op), 32'd0);
        check_eq({tag, " tx0"},    32'(ifc.o_tx_data), 32'd0);
        check_eq({tag, " start0"}, 32'(ifc.o_tx_start), 32'd0);
        check_eq({tag, " busy0"},  32'(ifc.o_busy), 32'd0);
        check_eq({tag, " err0"},   32'(ifc.o_err), 32'd0);
    endtask

    initial begin
        logic [5:0] ops [8];
        int base;
        logic [7:0] ra, rb;
        logic [5:0] rop;
        ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};
        n_checks      = 0;
        n_err         = 0;
        start_cnt     = 0;
        rst           = 1'b1;
        ifc.i_rx_data = 8'h00;
        ifc.i_rx_done = 1'b0;
        ifc.i_tx_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset");

        run_cmd("add", 8'h05, 8'h03, 8'h20, 8'h08);
        run_cmd("sub", 8'h03, 8'h05, 8'h22, 8'hFE);
        run_cmd("sra", 8'h80, 8'h02, 8'h03, 8'hE0);
        run_cmd("srl", 8'h80, 8'h02, 8'h02, 8'h20);

        // Invalid opcode
        base = start_cnt;
        send_byte(8'h0F);
        send_byte(8'h33);
        send_byte(8'h3F);
        check_eq("inv err", 32'(ifc.o_err), 32'd1);
        check_eq("inv busy", 32'(ifc.o_busy), 32'd0);
        check_eq("inv op_kept", 32'(ifc.o_alu_op), 32'h02);
        @(negedge clk);
        check_eq("inv err_once", 32'(ifc.o_err), 32'd0);
        @(negedge clk);
        check_eq("inv no_start", 32'(start_cnt - base), 32'd0);
        run_cmd("nor", 8'h0F, 8'h33, 8'h27, 8'hC0);

        // RX bytes during WAIT_TX are dropped
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h25);
        repeat (2) @(negedge clk);
        send_byte(8'hAA);
        check_eq("drop a_kept", 32'(ifc.o_alu_a), 32'h10);
        check_eq("drop busy", 32'(ifc.o_busy), 32'd1);
        ifc.i_rx_data = 8'hAA;
        ifc.i_rx_done = 1'b1;
        ifc.i_tx_done = 1'b1;
        @(negedge clk);
        ifc.i_rx_done = 1'b0;
        ifc.i_tx_done = 1'b0;
        check_eq("simul busy", 32'(ifc.o_busy), 32'd0);
        check_eq("simul a_kept", 32'(ifc.o_alu_a), 32'h10);
        run_cmd("and", 8'h01, 8'h01, 8'h24, 8'h01);

        // Reset while in WAIT_B
        send_byte(8'h11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("rst_b");

        // Reset during SEND
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h20);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("rst_send");
        base = start_cnt;
        pulse_tx_done();
        repeat (2) @(negedge clk);
        check_eq("stale busy", 32'(ifc.o_busy), 32'd0);
        check_eq("stale no_start", 32'(start_cnt - base), 32'd0);
        run_cmd("after_rst", 8'h05, 8'h03, 8'h20, 8'h08);

        // Back-to-back random valid commands
        for (int i = 0; i < 10; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom_range(0, 255));
            rop = ops[$urandom_range(0, 7)];
            run_cmd($sformatf("rnd%0d", i), ra, rb, {2'b00, rop}, ref_alu(ra, rb, rop));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
